// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline-stage registers: control states
// and the payload width of each inter-stage register.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_t;

  localparam int IF_ID_W  = 64;
  localparam int ID_EX_W  = 147;
  localparam int EX_MEM_W = 107;
  localparam int MEM_WB_W = 71;

endpackage

// File: rtl/pipe_slot.sv
// One storage entry of a pipeline stage: a data register with its valid flop.
// Clearing drops the valid bit only; the stale payload is left in place.
module pipe_slot #(
  parameter int                 WIDTH       = 32,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             valid
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;

  // Load wins over clear so a simultaneous refill keeps the entry valid.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (load) begin
      data_d  = d;
      valid_d = 1'b1;
    end else if (clear) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= RESET_VALUE;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign q     = data_q;
  assign valid = valid_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline-stage register with synchronous flush and an optional
// skid entry that registers in_ready without costing throughput.
module pipe_stage_reg #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit               SKID        = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  import pipe_pkg::*;

  pipe_state_t      state_q, state_d;
  logic             main_load, main_clear, main_valid;
  logic             skid_load, skid_clear, skid_valid;
  logic [WIDTH-1:0] main_in, skid_data;
  logic             in_xfer, out_xfer;

  assign in_xfer  = in_valid && in_ready && !flush;
  assign out_xfer = main_valid && out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= pipe_pkg::EMPTY;
    else          state_q <= state_d;
  end

  // The skid entry only ever drains into main, so main reloads from it in SKID.
  always_comb begin
    state_d    = state_q;
    main_load  = 1'b0;
    main_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    main_in    = (state_q == pipe_pkg::SKID) ? skid_data : in_data;
    if (flush) begin
      state_d    = pipe_pkg::EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      unique case (state_q)
        pipe_pkg::EMPTY: begin
          if (in_xfer) begin
            main_load = 1'b1;
            state_d   = pipe_pkg::FULL;
          end
        end
        pipe_pkg::FULL: begin
          if (in_xfer && out_xfer) begin
            main_load = 1'b1;
          end else if (in_xfer && SKID) begin
            skid_load = 1'b1;
            state_d   = pipe_pkg::SKID;
          end else if (out_xfer) begin
            main_clear = 1'b1;
            state_d    = pipe_pkg::EMPTY;
          end
        end
        pipe_pkg::SKID: begin
          if (out_xfer) begin
            main_load  = 1'b1;
            skid_clear = 1'b1;
            state_d    = pipe_pkg::FULL;
          end
        end
        default: state_d = pipe_pkg::EMPTY;
      endcase
    end
  end

  pipe_slot #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_main (
    .clock   (clock),
    .reset_n (reset_n),
    .load    (main_load),
    .clear   (main_clear),
    .d       (main_in),
    .q       (out_data),
    .valid   (main_valid)
  );

  generate
    if (SKID) begin : g_skid
      pipe_slot #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_skid (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (skid_load),
        .clear   (skid_clear),
        .d       (in_data),
        .q       (skid_data),
        .valid   (skid_valid)
      );
    end else begin : g_no_skid
      assign skid_data  = RESET_VALUE;
      assign skid_valid = 1'b0;
    end
  endgenerate

  // Skid mode keeps in_ready purely registered; otherwise it looks through out_ready.
  assign in_ready  = SKID ? !skid_valid : (!main_valid || out_ready);
  assign out_valid = main_valid;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised and directed check of pipe_stage_reg in three configurations
// against a bounded-FIFO reference model.
module tb_pipe_stage_reg;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] in_data;
  logic [2:0]  in_rdy;
  logic [2:0]  out_vld;
  logic [63:0] od_a, od_b;
  logic [6:0]  od_c;
  logic [63:0] got_data [3];

  always #5 clock = ~clock;

  pipe_stage_reg #(.WIDTH(64), .SKID(1'b1)) u_skid64 (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_rdy[0]), .in_data(in_data),
    .out_valid(out_vld[0]), .out_ready(out_ready), .out_data(od_a)
  );

  pipe_stage_reg #(.WIDTH(64), .SKID(1'b0)) u_noskid64 (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_rdy[1]), .in_data(in_data),
    .out_valid(out_vld[1]), .out_ready(out_ready), .out_data(od_b)
  );

  pipe_stage_reg #(.WIDTH(7), .SKID(1'b1)) u_skid7 (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_rdy[2]), .in_data(in_data[6:0]),
    .out_valid(out_vld[2]), .out_ready(out_ready), .out_data(od_c)
  );

  always_comb begin
    got_data[0] = od_a;
    got_data[1] = od_b;
    got_data[2] = {57'd0, od_c};
  end

  // Reference: each stage is a FIFO of capacity 2 (skid) or 1 (no skid).
  logic [63:0] m_data [3][2];
  int          m_cnt  [3];
  int          m_cap  [3] = '{2, 1, 2};
  logic [63:0] m_mask [3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7F};

  int checks = 0;
  int passes = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic bit model_ready(input int i);
    if (m_cap[i] == 2) return m_cnt[i] < 2;
    return (m_cnt[i] == 0) || out_ready;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("dut%0d out_valid", i), {63'd0, out_vld[i]}, {63'd0, m_cnt[i] != 0});
      checkOutput($sformatf("dut%0d in_ready", i), {63'd0, in_rdy[i]}, {63'd0, model_ready(i)});
      if (m_cnt[i] != 0)
        checkOutput($sformatf("dut%0d out_data", i), got_data[i], m_data[i][0]);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      bit rdy;
      rdy = model_ready(i);
      if (flush) begin
        m_cnt[i] = 0;
      end else begin
        if (m_cnt[i] != 0 && out_ready) begin
          m_data[i][0] = m_data[i][1];
          m_cnt[i]--;
        end
        if (in_valid && rdy) begin
          m_data[i][m_cnt[i]] = in_data & m_mask[i];
          m_cnt[i]++;
        end
      end
    end
  endtask

  // One cycle: drive inputs after the falling edge, check, then advance the model.
  task automatic applyStimulus(input bit iv, input logic [63:0] d, input bit ordy, input bit fl);
    @(negedge clock);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    check_all();
    model_step();
  endtask

  task automatic check_reset_values();
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("reset dut%0d out_valid", i), {63'd0, out_vld[i]}, 64'd0);
      checkOutput($sformatf("reset dut%0d in_ready", i), {63'd0, in_rdy[i]}, 64'd1);
      checkOutput($sformatf("reset dut%0d out_data", i), got_data[i], 64'd0);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    model_reset();
    #1;
    check_reset_values();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Fill the skid with A5, 5A, then reset asynchronously between edges.
    applyStimulus(1'b1, 64'hA5, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h5A, 1'b0, 1'b0);
    applyStimulus(1'b0, 64'h0,  1'b0, 1'b0);
    #2;
    in_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    applyStimulus(1'b1, 64'h1, 1'b1, 1'b0);
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);

    // Back-to-back streaming.
    for (int v = 16; v < 32; v++) applyStimulus(1'b1, 64'(v), 1'b1, 1'b0);
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);

    // Stall with back-pressure, then drain.
    applyStimulus(1'b1, 64'h1, 1'b1, 1'b0);
    applyStimulus(1'b1, 64'h2, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h3, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h3, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h3, 1'b1, 1'b0);
    applyStimulus(1'b1, 64'h3, 1'b1, 1'b0);
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);

    // Flush while full, with an input offered in the flush cycle.
    applyStimulus(1'b1, 64'h7, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h8, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h9, 1'b0, 1'b1);
    applyStimulus(1'b1, 64'hB, 1'b1, 1'b0);
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);

    // Simultaneous in/out transfer, then combinational in_ready drop in no-skid mode.
    applyStimulus(1'b1, 64'h5, 1'b1, 1'b0);
    applyStimulus(1'b1, 64'hC, 1'b1, 1'b0);
    applyStimulus(1'b0, 64'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);

    // Random traffic with occasional flushes.
    for (int n = 0; n < 10000; n++) begin
      applyStimulus(($urandom % 4) != 0, {$urandom, $urandom},
                    ($urandom % 3) != 0, ($urandom % 20) == 0);
    end
    applyStimulus(1'b0, 64'h0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
